// File: rtl/stack_mem_ctrl_if.sv
// Request/response handshake plus data-memory port of the stack/memory controller.
// The slave modport is the controller's view; the master modport is the requester/memory side.
interface stack_mem_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       resp_err;
   logic [7:0] sp;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;

   modport slave (
      input  req_valid, req_op, req_addr, req_data, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_err, sp,
             mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req_valid, req_op, req_addr, req_data, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_err, sp,
             mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Three-phase LOAD/STORE/PUSH/POP controller for a single-port data memory with a
// downward-growing hardware stack.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | ready for a request; memory port idle
//   S_ACCESS | memory port driven for the latched op; read data sampled at exit
//   S_RESP   | one-cycle resp_valid pulse with resp_data/resp_err
module stack_mem_ctrl #(
   parameter logic [7:0] SP_INIT  = 8'hFF,
   parameter logic [7:0] SP_LIMIT = 8'hC0
) (
   input logic             clk,
   input logic             reset,
   stack_mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   state_t     state_q,      state_d;
   logic [1:0] op_q,         op_d;
   logic       err_q,        err_d;
   logic [7:0] sp_q,         sp_d;
   logic [7:0] mem_addr_q,   mem_addr_d;
   logic [7:0] mem_wdata_q,  mem_wdata_d;
   logic       mem_we_q,     mem_we_d;
   logic       resp_valid_q, resp_valid_d;
   logic       resp_err_q,   resp_err_d;
   logic [7:0] resp_data_q,  resp_data_d;

   logic stack_full;
   logic stack_empty;

   assign stack_full  = (sp_q < SP_LIMIT);
   assign stack_empty = (sp_q == SP_INIT);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      err_d        = err_q;
      sp_d         = sp_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = mem_we_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_data_d  = resp_data_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               state_d     = S_ACCESS;
               op_d        = bus.req_op;
               mem_wdata_d = bus.req_data;
               err_d       = ((bus.req_op == OP_PUSH) && stack_full) ||
                             ((bus.req_op == OP_POP)  && stack_empty);
               case (bus.req_op)
                  OP_PUSH: mem_addr_d = sp_q;
                  OP_POP:  mem_addr_d = sp_q + 8'd1;
                  default: mem_addr_d = bus.req_addr;
               endcase
               mem_we_d = (bus.req_op == OP_STORE) ||
                          ((bus.req_op == OP_PUSH) && !stack_full);
            end
         end

         S_ACCESS: begin
            state_d      = S_RESP;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
            resp_data_d  = 8'h00;
            // Rejected push/pop leaves sp and resp_data untouched by the access.
            if (!err_q) begin
               case (op_q)
                  OP_PUSH: sp_d = sp_q - 8'd1;
                  OP_POP: begin
                     sp_d        = sp_q + 8'd1;
                     resp_data_d = bus.mem_rdata;
                  end
                  OP_LOAD: resp_data_d = bus.mem_rdata;
                  default: ;
               endcase
            end
         end

         S_RESP: begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
         end

         default: begin
            state_d      = S_IDLE;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LOAD;
         err_q        <= 1'b0;
         sp_q         <= SP_INIT;
         mem_addr_q   <= 8'h00;
         mem_wdata_q  <= 8'h00;
         mem_we_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         err_q        <= err_d;
         sp_q         <= sp_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.sp         = sp_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_we     = mem_we_q;

endmodule
